// File: rtl/io_map_pkg.sv
// Shared I/O map for the MCU peripheral bus: port addresses, status bit
// positions and the write-decode selector type.
package io_map_pkg;

  localparam logic [7:0] LED_PORT_ADDR  = 8'h40;
  localparam logic [7:0] SSEG_PORT_ADDR = 8'h81;
  localparam logic [7:0] SW_PORT_ADDR   = 8'h20;
  localparam logic [7:0] TX_PORT_ADDR   = 8'h90;
  localparam logic [7:0] STAT_PORT_ADDR = 8'h91;

  // Bit positions inside the status byte returned on STAT_PORT reads
  localparam int unsigned STAT_EMPTY = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_OVF   = 2;

  // Target of a strobed write
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LED,
    SEL_SSEG,
    SEL_TX,
    SEL_STAT
  } wsel_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with registered occupancy count. Output data is
// forced to zero while empty so stale entries never show on dout.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a full FIFO still accepts a push
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/io_port_responder.sv
// Responder side of the MCU I/O bus: strobed write decode into LED/SSEG
// registers and a TX FIFO, combinational read mux, switch synchronizer.
module io_port_responder
  import io_map_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  LED_PORT   = LED_PORT_ADDR,
  parameter logic [7:0]  SSEG_PORT  = SSEG_PORT_ADDR,
  parameter logic [7:0]  SW_PORT    = SW_PORT_ADDR,
  parameter logic [7:0]  TX_PORT    = TX_PORT_ADDR,
  parameter logic [7:0]  STAT_PORT  = STAT_PORT_ADDR
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       IO_STRB,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  output logic [7:0] IN_PORT,
  input  logic [7:0] SWITCHES,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  input  logic       TX_READY
);

  wsel_e      wsel;
  logic [7:0] leds_q, leds_d;
  logic [7:0] sseg_q, sseg_d;
  logic [7:0] sw_sync1_q, sw_sync2_q;
  logic       ovf_q, ovf_d;
  logic       fifo_empty, fifo_full;
  logic       push_req, push, pop;
  logic [7:0] status;

  // Write decode; only a strobed cycle selects a target
  always_comb begin
    wsel = SEL_NONE;
    if (IO_STRB) begin
      if      (PORT_ID == LED_PORT)  wsel = SEL_LED;
      else if (PORT_ID == SSEG_PORT) wsel = SEL_SSEG;
      else if (PORT_ID == TX_PORT)   wsel = SEL_TX;
      else if (PORT_ID == STAT_PORT) wsel = SEL_STAT;
    end
  end

  assign pop      = TX_VALID & TX_READY;
  assign push_req = (wsel == SEL_TX);
  assign push     = push_req & (~fifo_full | pop);

  // Peripheral register and sticky-overflow next state
  always_comb begin
    leds_d = leds_q;
    sseg_d = sseg_q;
    ovf_d  = ovf_q;
    if (wsel == SEL_LED)  leds_d = OUT_PORT;
    if (wsel == SEL_SSEG) sseg_d = OUT_PORT;
    if (wsel == SEL_STAT)           ovf_d = 1'b0;
    else if (push_req && !push)     ovf_d = 1'b1;
  end

  // Peripheral registers, overflow flag and two-flop switch synchronizer
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      leds_q     <= '0;
      sseg_q     <= '0;
      ovf_q      <= 1'b0;
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      leds_q     <= leds_d;
      sseg_q     <= sseg_d;
      ovf_q      <= ovf_d;
      sw_sync1_q <= SWITCHES;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (push),
    .pop   (pop),
    .din   (OUT_PORT),
    .dout  (TX_DATA),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign TX_VALID = ~fifo_empty;
  assign LEDS     = leds_q;
  assign SSEG     = sseg_q;

  // Read mux; side-effect free
  always_comb begin
    status             = '0;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_OVF]   = ovf_q;
    if      (PORT_ID == SW_PORT)   IN_PORT = sw_sync2_q;
    else if (PORT_ID == STAT_PORT) IN_PORT = status;
    else                           IN_PORT = '0;
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed self-checking bench for io_port_responder.
module tb_io_port_responder;

  logic       CLK;
  logic       RESET_N;
  logic       IO_STRB;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic [7:0] IN_PORT;
  logic [7:0] SWITCHES;
  logic [7:0] LEDS;
  logic [7:0] SSEG;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;

  int unsigned n_cmp;
  int unsigned n_err;

  io_port_responder #(
    .FIFO_DEPTH (8),
    .LED_PORT   (8'h40),
    .SSEG_PORT  (8'h81),
    .SW_PORT    (8'h20),
    .TX_PORT    (8'h90),
    .STAT_PORT  (8'h91)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .IO_STRB  (IO_STRB),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IN_PORT  (IN_PORT),
    .SWITCHES (SWITCHES),
    .LEDS     (LEDS),
    .SSEG     (SSEG),
    .TX_DATA  (TX_DATA),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    IO_STRB  = 1'b1;
    PORT_ID  = port;
    OUT_PORT = data;
    tick();
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
  endtask

  task automatic read_port(input logic [7:0] port);
    PORT_ID = port;
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (LEDS !== 8'h00) begin n_err++; $display("FAIL reset_leds got %h want %h", LEDS, 8'h00); end
    n_cmp++;
    if (SSEG !== 8'h00) begin n_err++; $display("FAIL reset_sseg got %h want %h", SSEG, 8'h00); end
    n_cmp++;
    if (TX_VALID !== 1'b0) begin n_err++; $display("FAIL reset_txvalid got %b want 0", TX_VALID); end
    n_cmp++;
    if (TX_DATA !== 8'h00) begin n_err++; $display("FAIL reset_txdata got %h want %h", TX_DATA, 8'h00); end
    read_port(8'h91);
    n_cmp++;
    if (IN_PORT !== 8'h01) begin n_err++; $display("FAIL reset_stat got %h want %h", IN_PORT, 8'h01); end
  endtask

  task automatic test_leds();
    io_write(8'h40, 8'h3C);
    n_cmp++;
    if (LEDS !== 8'h3C) begin n_err++; $display("FAIL led_write got %h want %h", LEDS, 8'h3C); end
    // no strobe: ignored
    PORT_ID  = 8'h40;
    OUT_PORT = 8'h77;
    tick();
    n_cmp++;
    if (LEDS !== 8'h3C) begin n_err++; $display("FAIL led_nostrobe got %h want %h", LEDS, 8'h3C); end
    io_write(8'h81, 8'h5A);
    n_cmp++;
    if (SSEG !== 8'h5A) begin n_err++; $display("FAIL sseg_write got %h want %h", SSEG, 8'h5A); end
    io_write(8'h55, 8'hFF);
    n_cmp++;
    if (LEDS !== 8'h3C) begin n_err++; $display("FAIL unmapped_leds got %h want %h", LEDS, 8'h3C); end
    n_cmp++;
    if (SSEG !== 8'h5A) begin n_err++; $display("FAIL unmapped_sseg got %h want %h", SSEG, 8'h5A); end
    n_cmp++;
    if (TX_VALID !== 1'b0) begin n_err++; $display("FAIL unmapped_tx got %b want 0", TX_VALID); end
  endtask

  task automatic test_switches();
    PORT_ID  = 8'h20;
    SWITCHES = 8'h9E;
    tick();
    n_cmp++;
    if (IN_PORT !== 8'h00) begin n_err++; $display("FAIL sw_one_edge got %h want %h", IN_PORT, 8'h00); end
    tick();
    n_cmp++;
    if (IN_PORT !== 8'h9E) begin n_err++; $display("FAIL sw_two_edges got %h want %h", IN_PORT, 8'h9E); end
    read_port(8'h33);
    n_cmp++;
    if (IN_PORT !== 8'h00) begin n_err++; $display("FAIL read_unmapped got %h want %h", IN_PORT, 8'h00); end
  endtask

  task automatic test_fifo_overflow();
    TX_READY = 1'b0;
    for (int i = 1; i <= 8; i++) io_write(8'h90, 8'(i));
    read_port(8'h91);
    n_cmp++;
    if (IN_PORT !== 8'h02) begin n_err++; $display("FAIL fifo_full_stat got %h want %h", IN_PORT, 8'h02); end
    io_write(8'h90, 8'h09);
    read_port(8'h91);
    n_cmp++;
    if (IN_PORT !== 8'h06) begin n_err++; $display("FAIL overflow_stat got %h want %h", IN_PORT, 8'h06); end
    TX_READY = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if (TX_VALID !== 1'b1 || TX_DATA !== 8'(i)) begin
        n_err++;
        $display("FAIL drain_%0d got valid=%b data=%h want valid=1 data=%h", i, TX_VALID, TX_DATA, 8'(i));
      end
      tick();
    end
    TX_READY = 1'b0;
    n_cmp++;
    if (TX_VALID !== 1'b0) begin n_err++; $display("FAIL drained_valid got %b want 0", TX_VALID); end
    n_cmp++;
    if (IN_PORT !== 8'h05) begin n_err++; $display("FAIL drained_stat got %h want %h", IN_PORT, 8'h05); end
    io_write(8'h91, 8'hAB);
    read_port(8'h91);
    n_cmp++;
    if (IN_PORT !== 8'h01) begin n_err++; $display("FAIL ovf_clear got %h want %h", IN_PORT, 8'h01); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_seq [8];
    TX_READY = 1'b0;
    for (int i = 1; i <= 8; i++) io_write(8'h90, 8'(i));
    TX_READY = 1'b1;
    IO_STRB  = 1'b1;
    PORT_ID  = 8'h90;
    OUT_PORT = 8'hEE;
    #1;
    n_cmp++;
    if (TX_DATA !== 8'h01) begin n_err++; $display("FAIL fullpp_head got %h want %h", TX_DATA, 8'h01); end
    tick();
    IO_STRB = 1'b0;
    read_port(8'h91);
    n_cmp++;
    if (IN_PORT !== 8'h02) begin n_err++; $display("FAIL fullpp_stat got %h want %h", IN_PORT, 8'h02); end
    for (int i = 0; i < 7; i++) exp_seq[i] = 8'(i + 2);
    exp_seq[7] = 8'hEE;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (TX_VALID !== 1'b1 || TX_DATA !== exp_seq[i]) begin
        n_err++;
        $display("FAIL fullpp_byte%0d got valid=%b data=%h want valid=1 data=%h", i, TX_VALID, TX_DATA, exp_seq[i]);
      end
      tick();
    end
    TX_READY = 1'b0;
    n_cmp++;
    if (IN_PORT !== 8'h01) begin n_err++; $display("FAIL fullpp_end_stat got %h want %h", IN_PORT, 8'h01); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got [$];
    TX_READY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      IO_STRB  = 1'b1;
      PORT_ID  = 8'h90;
      OUT_PORT = 8'(8'h10 + i);
      if (TX_VALID && TX_READY) got.push_back(TX_DATA);
      tick();
    end
    IO_STRB = 1'b0;
    PORT_ID = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (TX_VALID && TX_READY) got.push_back(TX_DATA);
      tick();
    end
    TX_READY = 1'b0;
    n_cmp++;
    if (got.size() != 20) begin n_err++; $display("FAIL wrap_count got %0d want %0d", got.size(), 20); end
    for (int i = 0; i < 20; i++) begin
      if (i < got.size()) begin
        n_cmp++;
        if (got[i] !== 8'(8'h10 + i)) begin
          n_err++;
          $display("FAIL wrap_byte%0d got %h want %h", i, got[i], 8'(8'h10 + i));
        end
      end
    end
    read_port(8'h91);
    n_cmp++;
    if (IN_PORT !== 8'h01) begin n_err++; $display("FAIL wrap_stat got %h want %h", IN_PORT, 8'h01); end
  endtask

  task automatic test_mid_reset();
    TX_READY = 1'b0;
    io_write(8'h40, 8'hA5);
    io_write(8'h90, 8'h61);
    io_write(8'h90, 8'h62);
    io_write(8'h90, 8'h63);
    n_cmp++;
    if (LEDS !== 8'hA5 || TX_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre got leds=%h valid=%b want leds=a5 valid=1", LEDS, TX_VALID);
    end
    PORT_ID = 8'h91;
    RESET_N = 1'b0;
    #1;
    n_cmp++;
    if (LEDS !== 8'h00) begin n_err++; $display("FAIL midrst_leds got %h want %h", LEDS, 8'h00); end
    n_cmp++;
    if (SSEG !== 8'h00) begin n_err++; $display("FAIL midrst_sseg got %h want %h", SSEG, 8'h00); end
    n_cmp++;
    if (TX_VALID !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", TX_VALID); end
    n_cmp++;
    if (TX_DATA !== 8'h00) begin n_err++; $display("FAIL midrst_data got %h want %h", TX_DATA, 8'h00); end
    n_cmp++;
    if (IN_PORT !== 8'h01) begin n_err++; $display("FAIL midrst_stat got %h want %h", IN_PORT, 8'h01); end
    RESET_N = 1'b1;
    tick();
    io_write(8'h90, 8'h7B);
    n_cmp++;
    if (TX_VALID !== 1'b1 || TX_DATA !== 8'h7B) begin
      n_err++;
      $display("FAIL postrst_push got valid=%b data=%h want valid=1 data=7b", TX_VALID, TX_DATA);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    RESET_N  = 1'b0;
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    SWITCHES = 8'h00;
    TX_READY = 1'b0;
    #12;
    RESET_N = 1'b1;
    tick();
    test_reset();
    test_leds();
    test_switches();
    test_fifo_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
